// File: rtl/led_seq_pkg.sv
// Shared definitions for the 8-LED pattern sequencer.
//   mode_t     : pattern mode encoding (also the oMODE output encoding)
//   dir_t      : bounce travel direction
//   INIT_*     : oLED value loaded when a mode is entered
//   mode_init  : maps a mode to its entry pattern
package led_seq_pkg;

    localparam int LED_W = 8;

    typedef enum logic [1:0] {
        MODE_CHASE  = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_FILL   = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    localparam logic [LED_W-1:0] INIT_CHASE  = 8'h01;
    localparam logic [LED_W-1:0] INIT_BOUNCE = 8'h01;
    localparam logic [LED_W-1:0] INIT_FILL   = 8'h00;
    localparam logic [LED_W-1:0] INIT_BLINK  = 8'h55;

    function automatic logic [LED_W-1:0] mode_init(input mode_t m);
        logic [LED_W-1:0] v;
        case (m)
            MODE_CHASE:  v = INIT_CHASE;
            MODE_BOUNCE: v = INIT_BOUNCE;
            MODE_FILL:   v = INIT_FILL;
            MODE_BLINK:  v = INIT_BLINK;
            default:     v = INIT_CHASE;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button debouncer: two-flop synchroniser, stability counter and rise pulse.
//   iCLK   : system clock
//   iRST   : asynchronous active-high reset (accepted level cleared to 0)
//   iBTN   : raw asynchronous button, active-high
//   oRISE  : one-cycle pulse when the accepted level goes 0 -> 1
module btn_debounce #(
    parameter int DB_W = 16
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iBTN,
    output logic oRISE
);

    localparam logic [DB_W-1:0] CNT_MAX = '1;
    localparam logic [DB_W-1:0] CNT_ONE = {{(DB_W-1){1'b0}}, 1'b1};

    logic            sync_p0;
    logic            sync_p1;
    logic            stable;
    logic [DB_W-1:0] cnt;

    // The counter measures how long the synchronised input has disagreed with
    // the accepted level; any return to agreement restarts the measurement, so
    // short glitches never reach CNT_MAX.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            stable  <= 1'b0;
            cnt     <= '0;
            oRISE   <= 1'b0;
        end else begin
            // stage p0 -> p1: metastability guard
            sync_p0 <= iBTN;
            sync_p1 <= sync_p0;
            oRISE   <= 1'b0;
            if (sync_p1 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= sync_p1;
                cnt    <= '0;
                // Only a press is reported; a release updates the level silently.
                oRISE  <= sync_p1;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// 8-LED pattern sequencer: step-rate prescaler, debounced mode button and a
// four-mode pattern FSM (chase, bounce, fill, blink).
//   iCLK    : system clock
//   iRST    : asynchronous active-high reset
//   iBTN    : raw mode-advance button (asynchronous, active-high)
//   iSW     : direction, 1 = toward LSB, 0 = toward MSB
//   iSPEED  : rate select, step period = 2^(DIV_W-iSPEED) clocks
//   oLED    : LED pattern
//   oMODE   : current mode (0 CHASE, 1 BOUNCE, 2 FILL, 3 BLINK)
//   oTICK   : one-cycle pulse in the cycle oLED has just stepped
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int DIV_W = 19,
    parameter int DB_W  = 16
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iBTN,
    input  logic             iSW,
    input  logic [1:0]       iSPEED,
    output logic [LED_W-1:0] oLED,
    output logic [1:0]       oMODE,
    output logic             oTICK
);

    localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_mask;
    logic             tick;
    logic             adv;

    mode_t            mode;
    mode_t            mode_nxt;
    dir_t             dir;
    dir_t             dir_nxt;
    logic [LED_W-1:0] led_nxt;
    logic             tick_nxt;

    btn_debounce #(
        .DB_W (DB_W)
    ) u_debounce (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .iBTN  (iBTN),
        .oRISE (adv)
    );

    // Faster speeds look at fewer low bits of the same counter, so a speed
    // change takes effect on the very next cycle without reloading anything.
    assign cnt_mask = {DIV_W{1'b1}} >> iSPEED;
    assign tick     = ((cnt & cnt_mask) == cnt_mask);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            cnt <= '0;
        end else if (adv) begin
            // A new mode always gets a full step period before its first step.
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            mode  <= MODE_CHASE;
            dir   <= DIR_LEFT;
            oLED  <= INIT_CHASE;
            oTICK <= 1'b0;
        end else begin
            mode  <= mode_nxt;
            dir   <= dir_nxt;
            oLED  <= led_nxt;
            oTICK <= tick_nxt;
        end
    end

    always_comb begin
        mode_nxt = mode;
        dir_nxt  = dir;
        led_nxt  = oLED;
        tick_nxt = 1'b0;
        if (adv) begin
            // Advance has priority: a coincident step is dropped, not deferred.
            mode_nxt = mode_t'(mode + 2'd1);
            led_nxt  = mode_init(mode_nxt);
            dir_nxt  = DIR_LEFT;
        end else if (tick) begin
            tick_nxt = 1'b1;
            case (mode)
                MODE_CHASE: begin
                    // Rotation gives the end-to-end wrap for a one-hot pattern.
                    if (iSW) begin
                        led_nxt = {oLED[0], oLED[LED_W-1:1]};
                    end else begin
                        led_nxt = {oLED[LED_W-2:0], oLED[LED_W-1]};
                    end
                end
                MODE_BOUNCE: begin
                    // Direction flips on the step that lands on an end bit, so
                    // the following step moves straight back inward.
                    if (dir == DIR_LEFT) begin
                        led_nxt = {oLED[LED_W-2:0], 1'b0};
                        if (oLED[LED_W-2]) begin
                            dir_nxt = DIR_RIGHT;
                        end
                    end else begin
                        led_nxt = {1'b0, oLED[LED_W-1:1]};
                        if (oLED[1]) begin
                            dir_nxt = DIR_LEFT;
                        end
                    end
                end
                MODE_FILL: begin
                    if (&oLED) begin
                        led_nxt = '0;
                    end else if (iSW) begin
                        led_nxt = {1'b1, oLED[LED_W-1:1]};
                    end else begin
                        led_nxt = {oLED[LED_W-2:0], 1'b1};
                    end
                end
                MODE_BLINK: begin
                    led_nxt = ~oLED;
                end
                default: begin
                    led_nxt = INIT_CHASE;
                end
            endcase
        end
    end

    assign oMODE = mode;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
`timescale 1ns/1ps
module tb_led_pattern_sequencer;

    localparam int DIV_W = 4;
    localparam int DB_W  = 2;
    // Edges from driving the button high to the new mode being visible:
    // 2 synchroniser flops, 3 counts to 2^DB_W-1, 1 accept/rise, 1 mode register.
    localparam int ADV_LAT = 7;

    logic       iCLK = 1'b0;
    logic       iRST;
    logic       iBTN;
    logic       iSW;
    logic [1:0] iSPEED;
    logic [7:0] oLED;
    logic [1:0] oMODE;
    logic       oTICK;

    always #5 iCLK = ~iCLK;

    led_pattern_sequencer #(
        .DIV_W (DIV_W),
        .DB_W  (DB_W)
    ) dut (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iBTN   (iBTN),
        .iSW    (iSW),
        .iSPEED (iSPEED),
        .oLED   (oLED),
        .oMODE  (oMODE),
        .oTICK  (oTICK)
    );

    typedef struct {
        logic [7:0] led;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   adv_at = -1;

    // Reference model state
    logic [3:0] m_cnt;
    logic [1:0] m_mode;
    logic       m_dir;    // 0 = toward MSB, 1 = toward LSB
    logic [7:0] m_led;
    int         m_steps;  // steps since last mode entry

    logic [7:0] prev_led;
    logic [1:0] prev_mode;

    function automatic logic [7:0] init_of(input logic [1:0] m);
        case (m)
            2'd0:    return 8'h01;
            2'd1:    return 8'h01;
            2'd2:    return 8'h00;
            default: return 8'h55;
        endcase
    endfunction

    task automatic model_reset();
        m_cnt   = 4'd0;
        m_mode  = 2'd0;
        m_dir   = 1'b0;
        m_led   = 8'h01;
        m_steps = 0;
        adv_at  = -1;
        sb.delete();
    endtask

    task automatic model_step(input logic sw);
        case (m_mode)
            2'd0: begin
                if (sw) m_led = (m_led == 8'h01) ? 8'h80 : (m_led >> 1);
                else    m_led = (m_led == 8'h80) ? 8'h01 : (m_led << 1);
            end
            2'd1: begin
                if (!m_dir) begin
                    m_led = m_led << 1;
                    if (m_led == 8'h80) m_dir = 1'b1;
                end else begin
                    m_led = m_led >> 1;
                    if (m_led == 8'h01) m_dir = 1'b0;
                end
            end
            2'd2: begin
                if (m_led == 8'hFF) m_led = 8'h00;
                else if (sw)        m_led = {1'b1, m_led[7:1]};
                else                m_led = {m_led[6:0], 1'b1};
            end
            default: m_led = ~m_led;
        endcase
        m_steps++;
    endtask

    // One clock: advance the model on the edge using the inputs that were
    // present at the edge, push any predicted step, return 2ns after the edge.
    task automatic cycle();
        logic [3:0] mask;
        logic       tk;
        @(posedge iCLK);
        cyc++;
        if (iRST) begin
            model_reset();
        end else begin
            mask = 4'hF >> iSPEED;
            tk   = ((m_cnt & mask) == mask);
            if (cyc == adv_at) begin
                m_mode  = m_mode + 2'd1;
                m_led   = init_of(m_mode);
                m_dir   = 1'b0;
                m_cnt   = 4'd0;
                m_steps = 0;
            end else begin
                if (tk) begin
                    model_step(iSW);
                    sb.push_back('{led: m_led, cyc: cyc});
                end
                m_cnt = m_cnt + 4'd1;
            end
        end
        #2;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_steps(input int n);
        int i;
        i = 0;
        while (m_steps < n && i < 2000) begin
            cycle();
            i++;
        end
        if (m_steps < n) begin
            checks++;
            errors++;
            $display("FAIL step_timeout: steps %0d, required %0d", m_steps, n);
        end
    endtask

    // Scoreboard monitor: every oTICK pops one prediction; predictions that
    // pass without a tick, and oLED changes without a tick, are errors.
    always @(posedge iCLK) begin
        exp_t e;
        #1;
        if (iRST) begin
            prev_led  = oLED;
            prev_mode = oMODE;
        end else begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_tick: no oTICK at cycle %0d, required step to %h", e.cyc, e.led);
            end
            if (oTICK) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_tick: cycle %0d oLED %h, required no step", cyc, oLED);
                end else begin
                    e = sb.pop_front();
                    if (oLED !== e.led || e.cyc != cyc) begin
                        errors++;
                        $display("FAIL step: cycle %0d oLED %h, required cycle %0d oLED %h", cyc, oLED, e.cyc, e.led);
                    end
                end
            end else if (oLED !== prev_led && oMODE === prev_mode) begin
                checks++;
                errors++;
                $display("FAIL silent_change: oLED %h -> %h without oTICK", prev_led, oLED);
            end
            prev_led  = oLED;
            prev_mode = oMODE;
        end
    end

    // Drive the button for hold cycles; when an advance is expected, check the
    // new mode on the edge it lands.
    task automatic press(input int hold, input bit expect_adv);
        int a;
        a      = expect_adv ? cyc + ADV_LAT : -1;
        adv_at = a;
        iBTN   = 1'b1;
        for (int i = 0; i < hold || (a >= 0 && cyc < a); i++) begin
            if (i == hold) iBTN = 1'b0;
            cycle();
            if (cyc == a) begin
                checks++;
                if (oMODE !== m_mode || oLED !== m_led || oTICK !== 1'b0) begin
                    errors++;
                    $display("FAIL advance: mode %0d led %h tick %b, required mode %0d led %h tick 0",
                             oMODE, oLED, oTICK, m_mode, m_led);
                end
            end
        end
        iBTN = 1'b0;
        run(15);
    endtask

    task automatic test_reset();
        iRST = 1'b1; iBTN = 1'b0; iSW = 1'b0; iSPEED = 2'd0;
        cycle();
        cycle();
        checks++;
        if (oLED !== 8'h01 || oMODE !== 2'd0 || oTICK !== 1'b0) begin
            errors++;
            $display("FAIL reset: led %h mode %0d tick %b, required 01 0 0", oLED, oMODE, oTICK);
        end
        iRST = 1'b0;
    endtask

    task automatic test_chase_left();
        iSW = 1'b0;
        run(16);
        checks++;
        if (oLED !== 8'h02) begin
            errors++;
            $display("FAIL chase_left_first: led %h, required 02", oLED);
        end
        run(112);
        checks++;
        if (oLED !== 8'h01) begin
            errors++;
            $display("FAIL chase_left_wrap: led %h, required 01", oLED);
        end
    endtask

    task automatic test_chase_right();
        iSW = 1'b1;
        run(16);
        checks++;
        if (oLED !== 8'h80) begin
            errors++;
            $display("FAIL chase_right_wrap: led %h, required 80", oLED);
        end
        run(16);
        checks++;
        if (oLED !== 8'h40) begin
            errors++;
            $display("FAIL chase_right: led %h, required 40", oLED);
        end
        run(8);
        iSW = 1'b0;
        run(8);
        checks++;
        if (oLED !== 8'h80) begin
            errors++;
            $display("FAIL chase_toggle: led %h, required 80", oLED);
        end
    endtask

    task automatic test_button();
        press(1, 1'b0);
        run(10);
        checks++;
        if (oMODE !== 2'd0) begin
            errors++;
            $display("FAIL glitch: mode %0d, required 0", oMODE);
        end
        press(5, 1'b1);
        checks++;
        if (oMODE !== 2'd1) begin
            errors++;
            $display("FAIL hold5_mode: mode %0d, required 1", oMODE);
        end
    endtask

    task automatic test_bounce();
        wait_steps(15);
        checks++;
        if (oLED !== 8'h02 || oMODE !== 2'd1) begin
            errors++;
            $display("FAIL bounce15: led %h mode %0d, required 02 1", oLED, oMODE);
        end
    endtask

    task automatic test_hold_long();
        press(40, 1'b1);
        checks++;
        if (oMODE !== 2'd2) begin
            errors++;
            $display("FAIL hold_long: mode %0d, required 2", oMODE);
        end
    endtask

    task automatic test_fill();
        iSW = 1'b0;
        wait_steps(8);
        checks++;
        if (oLED !== 8'hFF) begin
            errors++;
            $display("FAIL fill_full: led %h, required ff", oLED);
        end
        wait_steps(9);
        checks++;
        if (oLED !== 8'h00) begin
            errors++;
            $display("FAIL fill_clear: led %h, required 00", oLED);
        end
    endtask

    task automatic test_blink();
        press(5, 1'b1);
        checks++;
        if (oMODE !== 2'd3 || oLED !== 8'h55) begin
            errors++;
            $display("FAIL blink_init: mode %0d led %h, required 3 55", oMODE, oLED);
        end
        wait_steps(1);
        checks++;
        if (oLED !== 8'hAA) begin
            errors++;
            $display("FAIL blink_aa: led %h, required aa", oLED);
        end
        wait_steps(2);
        checks++;
        if (oLED !== 8'h55) begin
            errors++;
            $display("FAIL blink_55: led %h, required 55", oLED);
        end
    endtask

    task automatic test_adv_on_tick();
        int ticks;
        // Press so the advance lands exactly on a step edge (16 - 9 = ADV_LAT).
        for (int i = 0; i < 20 && m_cnt != 4'd9; i++) cycle();
        press(5, 1'b1);
        checks++;
        if (oMODE !== 2'd0 || oLED !== 8'h01) begin
            errors++;
            $display("FAIL adv_on_tick: mode %0d led %h, required 0 01", oMODE, oLED);
        end
        iSPEED = 2'd3;
        ticks  = 0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            if (oTICK === 1'b1) ticks++;
        end
        checks++;
        if (ticks != 8) begin
            errors++;
            $display("FAIL speed3: %0d ticks in 16 clocks, required 8", ticks);
        end
        for (int i = 0; i < 4; i++) press(5, 1'b1);
        checks++;
        if (oMODE !== 2'd0) begin
            errors++;
            $display("FAIL mode_wrap: mode %0d, required 0", oMODE);
        end
        iSPEED = 2'd0;
    endtask

    task automatic test_midreset();
        press(5, 1'b1);
        run(40);
        iRST = 1'b1;
        #1;
        checks++;
        if (oLED !== 8'h01 || oMODE !== 2'd0 || oTICK !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: led %h mode %0d tick %b, required 01 0 0", oLED, oMODE, oTICK);
        end
        cycle();
        cycle();
        iRST = 1'b0;
        iSW  = 1'b0;
        wait_steps(1);
        checks++;
        if (oLED !== 8'h02 || oMODE !== 2'd0) begin
            errors++;
            $display("FAIL resume_chase: led %h mode %0d, required 02 0", oLED, oMODE);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_chase_left();
        test_chase_right();
        test_button();
        test_bounce();
        test_hold_long();
        test_fill();
        test_blink();
        test_adv_on_tick();
        test_midreset();
        run(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
